// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer between rename and commit
// Frees overwritten physical registers at retire and drives branch recovery on mispredict.
module reorder_buffer #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_valid,
    input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
    input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
    input  logic                  dispatch_reg_write,
    input  logic                  dispatch_is_branch,
    input  logic                  complete_valid,
    input  logic [ROB_WIDTH-1:0]  complete_tag,
    input  logic                  complete_mispredict,
    output logic                  rob_ready,
    output logic                  rob_empty,
    output logic                  commit_en,
    output logic [PREG_WIDTH-1:0] commit_old_preg,
    output logic                  retire_valid,
    output logic                  branch_mispredict,
    output logic [ROB_WIDTH-1:0]  mispredict_tag,
    output logic                  tag_error
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL = (ROB_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]      valid, done, reg_write, is_branch;
    logic [DEPTH-1:0]      valid_nxt, done_nxt, younger;
    logic [PREG_WIDTH-1:0] old_prd [DEPTH];
    logic [ROB_WIDTH-1:0]  head, tail, br_off, span;
    logic [ROB_WIDTH:0]    count, count_nxt;
    logic                  disp_acc, disp_wr, retire, mp;

    assign rob_ready = count != FULL;
    assign rob_empty = count == '0;

    always_comb begin
        disp_acc = dispatch_valid && rob_ready && !branch_mispredict;
        retire   = valid[head] && done[head];
        mp       = complete_valid && complete_mispredict && valid[complete_tag] && is_branch[complete_tag];
        // A dispatch racing a mispredict is younger than the branch, so it is simply not kept
        disp_wr  = disp_acc && !mp;
        br_off   = complete_tag - head;
        span     = br_off + ROB_WIDTH'(1);
        for (int i = 0; i < DEPTH; i++)
            younger[i] = (ROB_WIDTH'(i) - head) > br_off;
        valid_nxt = valid;
        done_nxt  = done;
        if (disp_wr) begin
            valid_nxt[dispatch_rob_tag] = 1'b1;
            done_nxt[dispatch_rob_tag]  = 1'b0;
        end
        if (complete_valid && valid[complete_tag])
            done_nxt[complete_tag] = 1'b1;
        if (retire) begin
            valid_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
        if (mp) begin
            valid_nxt = valid_nxt & ~younger;
            done_nxt  = done_nxt & ~younger;
        end
        // Occupancy after a flush is the distance head..branch; a zero span only means full if it was full
        count_nxt = mp ? ((span == '0 && count == FULL) ? FULL : {1'b0, span}) - (ROB_WIDTH + 1)'(retire)
                       : count + (ROB_WIDTH + 1)'(disp_acc) - (ROB_WIDTH + 1)'(retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            valid             <= '0;
            done              <= '0;
            reg_write         <= '0;
            is_branch         <= '0;
            for (int i = 0; i < DEPTH; i++)
                old_prd[i] <= '0;
            commit_en         <= 1'b0;
            commit_old_preg   <= '0;
            retire_valid      <= 1'b0;
            branch_mispredict <= 1'b0;
            mispredict_tag    <= '0;
            tag_error         <= 1'b0;
        end else begin
            head              <= head + ROB_WIDTH'(retire);
            tail              <= mp ? complete_tag + ROB_WIDTH'(1) : tail + ROB_WIDTH'(disp_acc);
            count             <= count_nxt;
            valid             <= valid_nxt;
            done              <= done_nxt;
            retire_valid      <= retire;
            commit_en         <= retire && reg_write[head];
            commit_old_preg   <= (retire && reg_write[head]) ? old_prd[head] : '0;
            branch_mispredict <= mp;
            if (mp)
                mispredict_tag <= complete_tag;
            if (disp_acc && dispatch_rob_tag != tail)
                tag_error <= 1'b1;
            if (disp_wr) begin
                reg_write[dispatch_rob_tag] <= dispatch_reg_write;
                is_branch[dispatch_rob_tag] <= dispatch_is_branch;
                old_prd[dispatch_rob_tag]   <= dispatch_old_prd;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer
// Expected commits are queued at dispatch in program order and checked on each retire pulse.
module tb_reorder_buffer;
    localparam int PW = 7;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dispatch_valid = 1'b0;
    logic [RW-1:0] dispatch_rob_tag = '0;
    logic [PW-1:0] dispatch_old_prd = '0;
    logic          dispatch_reg_write = 1'b0;
    logic          dispatch_is_branch = 1'b0;
    logic          complete_valid = 1'b0;
    logic [RW-1:0] complete_tag = '0;
    logic          complete_mispredict = 1'b0;
    logic          rob_ready, rob_empty, commit_en, retire_valid, branch_mispredict, tag_error;
    logic [PW-1:0] commit_old_preg;
    logic [RW-1:0] mispredict_tag;

    typedef struct packed {
        logic          rw;
        logic [PW-1:0] p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    reorder_buffer #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .dispatch_valid      (dispatch_valid),
        .dispatch_rob_tag    (dispatch_rob_tag),
        .dispatch_old_prd    (dispatch_old_prd),
        .dispatch_reg_write  (dispatch_reg_write),
        .dispatch_is_branch  (dispatch_is_branch),
        .complete_valid      (complete_valid),
        .complete_tag        (complete_tag),
        .complete_mispredict (complete_mispredict),
        .rob_ready           (rob_ready),
        .rob_empty           (rob_empty),
        .commit_en           (commit_en),
        .commit_old_preg     (commit_old_preg),
        .retire_valid        (retire_valid),
        .branch_mispredict   (branch_mispredict),
        .mispredict_tag      (mispredict_tag),
        .tag_error           (tag_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Retire monitor: every retire pulse must match the oldest outstanding instruction
    always @(negedge clk) begin
        if (reset) begin
            if (retire_valid) begin
                if (sb.size() == 0) begin
                    check("unexp_retire", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("commit_en", commit_en, mon_e.rw);
                    check("commit_old_preg", commit_old_preg, mon_e.rw ? mon_e.p : '0);
                end
            end else begin
                check("stray_commit", commit_en, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        dispatch_valid = 1'b0;
        complete_valid = 1'b0;
        complete_mispredict = 1'b0;
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rob_ready"}, rob_ready, 1);
        check({pfx, "_rob_empty"}, rob_empty, 1);
        check({pfx, "_commit_en"}, commit_en, 0);
        check({pfx, "_commit_old_preg"}, commit_old_preg, 0);
        check({pfx, "_retire_valid"}, retire_valid, 0);
        check({pfx, "_branch_mispredict"}, branch_mispredict, 0);
        check({pfx, "_mispredict_tag"}, mispredict_tag, 0);
        check({pfx, "_tag_error"}, tag_error, 0);
    endtask

    task automatic disp(input int t, input logic rw, input int p, input logic br, input logic push);
        dispatch_valid = 1'b1;
        dispatch_rob_tag = RW'(t);
        dispatch_old_prd = PW'(p);
        dispatch_reg_write = rw;
        dispatch_is_branch = br;
        if (push)
            sb.push_back('{rw: rw, p: PW'(p)});
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic comp(input int t, input logic mp);
        complete_valid = 1'b1;
        complete_tag = RW'(t);
        complete_mispredict = mp;
        tick();
        complete_valid = 1'b0;
        complete_mispredict = 1'b0;
    endtask

    task automatic drain(input string pfx);
        int n = 0;
        while ((!rob_empty || sb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check({pfx, "_pending"}, sb.size(), 0);
        check({pfx, "_rob_empty"}, rob_empty, 1);
    endtask

    initial begin
        apply_reset();
        check_reset_outputs("rst");

        // Out-of-order completion, in-order retire
        for (int i = 0; i < 3; i++)
            disp(i, 1'b1, 10 + i, 1'b0, 1'b1);
        comp(2, 1'b0);
        comp(0, 1'b0);
        comp(1, 1'b0);
        drain("basic");

        // Full buffer back-pressure
        apply_reset();
        for (int i = 0; i < 16; i++)
            disp(i, 1'b1, 20 + i, 1'b0, 1'b1);
        check("full_ready", rob_ready, 0);
        check("full_empty", rob_empty, 0);
        disp(0, 1'b1, 99, 1'b0, 1'b0);
        check("full_ready2", rob_ready, 0);
        comp(0, 1'b0);
        check("ready_pre_retire", rob_ready, 0);
        tick();
        check("ready_post_retire", rob_ready, 1);
        for (int i = 1; i < 16; i++)
            comp(i, 1'b0);
        drain("full");

        // Mispredict flush
        apply_reset();
        for (int i = 0; i < 6; i++)
            disp(i, 1'b1, 30 + i, i == 2, 1'b1);
        comp(2, 1'b1);
        check("bm_pulse", branch_mispredict, 1);
        check("bm_tag", mispredict_tag, 2);
        while (sb.size() > 3)
            void'(sb.pop_back());
        disp(3, 1'b1, 77, 1'b0, 1'b0);
        check("bm_single", branch_mispredict, 0);
        comp(4, 1'b0);
        disp(3, 1'b1, 40, 1'b0, 1'b1);
        check("bm_tail", tag_error, 0);
        comp(0, 1'b0);
        comp(1, 1'b0);
        comp(3, 1'b0);
        drain("flush");

        // Non-writing instruction retires without freeing a register
        apply_reset();
        disp(0, 1'b0, 55, 1'b0, 1'b1);
        comp(0, 1'b0);
        drain("store");

        // Streaming 40 instructions through wrapping pointers
        apply_reset();
        for (int i = 0; i < 43; i++) begin
            dispatch_valid = i < 40;
            dispatch_rob_tag = RW'(i);
            dispatch_old_prd = PW'(i + 50);
            dispatch_reg_write = (i % 5) != 0;
            dispatch_is_branch = 1'b0;
            if (i < 40)
                sb.push_back('{rw: (i % 5) != 0, p: PW'(i + 50)});
            complete_valid = i >= 3;
            complete_tag = RW'((i - 3) ^ 1);
            complete_mispredict = 1'b0;
            tick();
        end
        dispatch_valid = 1'b0;
        complete_valid = 1'b0;
        drain("wrap");
        check("wrap_tag_error", tag_error, 0);

        // Tag mismatch is sticky; reset mid-stream clears everything at once
        apply_reset();
        disp(0, 1'b1, 60, 1'b0, 1'b1);
        disp(1, 1'b1, 61, 1'b0, 1'b1);
        check("tag_ok", tag_error, 0);
        disp(3, 1'b1, 63, 1'b0, 1'b1);
        check("tag_err_set", tag_error, 1);
        tick();
        tick();
        check("tag_err_sticky", tag_error, 1);
        comp(0, 1'b0);
        tick();
        check("pre_rst_commit", commit_en, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        sb.delete();
        tick();
        reset = 1'b1;
        disp(0, 1'b1, 70, 1'b0, 1'b1);
        comp(0, 1'b0);
        drain("post_rst");
        check("post_rst_tag_error", tag_error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer directly downstream of the rename stage.
- Accepts one renamed instruction per cycle, indexed by the ROB tag that rename assigned, and collects completions from the writeback bus.
- Retires instructions in program order, returning each overwritten physical register to rename's free list through the commit interface.
- Detects a mispredicted branch at completion, flushes all younger entries, and drives rename's branch-recovery inputs.

Parameters:
PREG_WIDTH, 7, physical register index width
ROB_WIDTH, 4, tag width; DEPTH = 2**ROB_WIDTH entries

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
dispatch_valid  input  1  renamed instruction present this cycle
dispatch_rob_tag  input  ROB_WIDTH  tag assigned by rename
dispatch_old_prd  input  PREG_WIDTH  previous mapping of rd, freed at retire
dispatch_reg_write  input  1  instruction writes a non-x0 register
dispatch_is_branch  input  1  instruction is a branch
complete_valid  input  1  writeback bus reports a finished instruction
complete_tag  input  ROB_WIDTH  tag of finished instruction
complete_mispredict  input  1  finished branch was mispredicted
rob_ready  output  1  space available; drives rename i_ready
rob_empty  output  1  no valid entries
commit_en  output  1  free commit_old_preg this cycle
commit_old_preg  output  PREG_WIDTH  register returned to free list
retire_valid  output  1  one instruction retired this cycle
branch_mispredict  output  1  one-cycle recovery pulse to rename
mispredict_tag  output  ROB_WIDTH  tag of the mispredicted branch
tag_error  output  1  sticky: dispatch tag disagreed with internal tail

Behaviour:
- Entry fields: valid, done, reg_write, is_branch, old_prd.
- Pointers: head and tail are ROB_WIDTH bits and wrap modulo DEPTH. count is ROB_WIDTH+1 bits, range 0..DEPTH.
- Reset (reset=0, asynchronous):
  - head=tail=count=0; all valid and done bits cleared.
  - Registered outputs go to 0: commit_en, commit_old_preg, retire_valid, branch_mispredict, mispredict_tag, tag_error.
  - rob_ready=1, rob_empty=1.
  - Reset asserted mid-operation discards all entries immediately.
- rob_ready = (count != DEPTH), combinational from registers. rob_empty = (count == 0).
- Dispatch is accepted when dispatch_valid && rob_ready && !branch_mispredict:
  - Entry[dispatch_rob_tag] is written with valid=1, done=0 and the payload fields.
  - tail increments by 1.
  - If dispatch_rob_tag != tail, tag_error is set to 1 and stays set until reset; the write still uses dispatch_rob_tag.
  - Dispatch with rob_ready=0 is ignored.
- Completion: when complete_valid and entry[complete_tag].valid, set done=1. Completion of an invalid entry is ignored.
- Retire: when entry[head].valid && entry[head].done:
  - Next cycle: retire_valid=1, commit_en=entry.reg_write, commit_old_preg=old_prd (0 if !reg_write).
  - head increments by 1 and the entry is cleared.
  - Latency from done being set to commit_en = 1 cycle; one retire per cycle max.
  - commit_en and retire_valid are single-cycle pulses.
- Mispredict: when complete_valid && complete_mispredict && entry[complete_tag].valid && entry[complete_tag].is_branch:
  - Next edge: branch_mispredict=1 (one cycle), mispredict_tag=complete_tag.
  - tail becomes complete_tag+1 (mod DEPTH); every entry strictly younger than complete_tag, up to the old tail, has valid cleared.
  - count is recomputed as (complete_tag - head + 1) mod DEPTH, or DEPTH when that result is 0 and the ROB was full. It is adjusted by -1 if the head retires in the same cycle.
  - The branch entry itself is marked done and retires normally.
  - complete_mispredict on a non-branch entry sets done only.
- Simultaneous events:
  - Dispatch + retire in one cycle: count unchanged.
  - Dispatch + mispredict completion in one cycle: the dispatched entry is younger and is flushed.
  - Retire of head + mispredict in one cycle: both take effect.
  - While branch_mispredict=1, dispatch is blocked.
- Wrap-around: tag DEPTH-1 is followed by tag 0. The full/empty distinction comes only from count.

Test Plan:
- Reset, then dispatch tags 0,1,2 (reg_write=1, old_prd=10,11,12); complete 2,0,1 -> commit_old_preg 10,11,12 on consecutive cycles, retiring in order; rob_empty=1 afterwards.
- Dispatch 16 entries without completions -> rob_ready=0 after the 16th; a 17th dispatch is ignored; completing tag 0 -> rob_ready=1 one cycle after the retire.
- Dispatch tags 0..5 with tag 2 a branch; complete tag 2 with mispredict=1 -> branch_mispredict pulse, mispredict_tag=2, tail=3; tags 3..5 flushed; a later completion of tag 4 is ignored.
- Dispatch a store (reg_write=0) at tag 0, then complete it -> retire_valid=1, commit_en=0.
- Fill and drain 40 instructions so pointers wrap -> order is preserved and tag 15 is followed by tag 0.
- Dispatch tag 3 while internal tail=2 -> tag_error=1 and stays set until reset; assert reset mid-stream -> all outputs return to reset values immediately.
